// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared types and default constants for the MEM-stage SRAM
//               controller (state encoding, geometry, timing defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

  // Default byte address that maps onto SRAM half-word pair 0
  localparam int c_base_addr   = 1024;
  // Default clock cycles held per 16-bit half access
  localparam int c_wait_cycles = 2;
  // Default SRAM address width (16-bit locations)
  localparam int c_sram_addr_w = 18;
  // Width of one SRAM location
  localparam int c_half_w      = 16;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : sram_ctrl_pkg
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : sram_wait_counter
// Description : Per-phase wait counter; flags the last cycle of a phase
//               (count == WAIT_CYCLES-1). Clear has priority over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int c_cnt_w = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [c_cnt_w-1:0] r_cnt;

  // Count cycles within a phase; restart whenever a phase is (re)entered
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == c_cnt_w'(WAIT_CYCLES - 1));

endmodule : sram_wait_counter
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : MEM-stage memory controller. Splits each 32-bit load/store
//               into two 16-bit accesses on an asynchronous SRAM and holds
//               ready low while busy so the pipeline freezes.
//               Optional macro SRAM_LAST_READ_HIT_EN adds a one-entry
//               last-read buffer that short-circuits repeated reads.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int BASE_ADDR   = c_base_addr,
  parameter int WAIT_CYCLES = c_wait_cycles,
  parameter int SRAM_ADDR_W = c_sram_addr_w
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [31:0]            address,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic [c_half_w-1:0]    SRAM_DQ_O,
  input  logic [c_half_w-1:0]    SRAM_DQ_I,
  output logic                   SRAM_DQ_OE,
  output logic                   SRAM_WE_N
);

  // Word index width: one SRAM address bit selects the half
  localparam int c_word_w = SRAM_ADDR_W - 1;

  state_t                r_state;
  state_t                w_next;
  logic [c_word_w-1:0]   r_word;
  logic [31:0]           r_wdata;
  logic                  r_wr;
  logic [31:0]           r_rdata;

  logic                  w_req;
  logic [31:0]           w_addr_off;
  logic [c_word_w-1:0]   w_word;
  logic                  w_unused_bits;
  logic                  w_tc;
  logic                  w_cnt_clr;
  logic                  w_cnt_en;
  logic                  w_hit;
  logic                  w_start;

  assign w_req      = MEM_R_EN | MEM_W_EN;
  assign w_start    = (r_state == IDLE) && w_req;
  // Byte offset from the SRAM window; byte lane bits and overflow wrap away
  assign w_addr_off = address - 32'(BASE_ADDR);
  assign w_word     = w_addr_off[c_word_w+1:2];
  assign w_unused_bits = ^{w_addr_off[31:c_word_w+2], w_addr_off[1:0]};

  // Counter restarts in every non-phase state and when a phase ends
  assign w_cnt_clr = (r_state == IDLE) || (r_state == DONE) || w_tc;
  assign w_cnt_en  = (r_state == LOW) || (r_state == HIGH);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

`ifdef SRAM_LAST_READ_HIT_EN
  logic                r_buf_vld;
  logic [c_word_w-1:0] r_buf_word;
  logic [31:0]         r_buf_data;

  // A pure read (write has priority when both are set) of the buffered word
  assign w_hit = MEM_R_EN && !MEM_W_EN && r_buf_vld && (r_buf_word == w_word);

  // Track the most recent completed SRAM read; any accepted write invalidates
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_vld  <= 1'b0;
      r_buf_word <= '0;
      r_buf_data <= '0;
    end else if (w_start && MEM_W_EN) begin
      r_buf_vld <= 1'b0;
    end else if ((r_state == HIGH) && w_tc && !r_wr) begin
      r_buf_vld  <= 1'b1;
      r_buf_word <= r_word;
      r_buf_data <= {SRAM_DQ_I, r_rdata[15:0]};
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // Next-state selection for the two-half access sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = w_hit ? DONE : LOW;
      LOW:     if (w_tc)  w_next = HIGH;
      HIGH:    if (w_tc)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the request when it is accepted; later input changes are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
    end else if (w_start) begin
      r_word  <= w_word;
      r_wdata <= wdata;
      r_wr    <= MEM_W_EN;
    end
  end

  // Assemble load data half by half on the last cycle of each phase
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if ((r_state == LOW) && w_tc && !r_wr) begin
      r_rdata[15:0] <= SRAM_DQ_I;
    end else if ((r_state == HIGH) && w_tc && !r_wr) begin
      r_rdata[31:16] <= SRAM_DQ_I;
`ifdef SRAM_LAST_READ_HIT_EN
    end else if (w_start && w_hit) begin
      r_rdata <= r_buf_data;
`endif
    end
  end

  // SRAM pin drive: only the LOW/HIGH phases touch the bus
  always_comb begin
    SRAM_ADDR  = '0;
    SRAM_DQ_O  = '0;
    SRAM_DQ_OE = 1'b0;
    SRAM_WE_N  = 1'b1;
    if (r_state == LOW) begin
      SRAM_ADDR  = {r_word, 1'b0};
      SRAM_DQ_O  = r_wr ? r_wdata[15:0] : '0;
      SRAM_DQ_OE = r_wr;
      SRAM_WE_N  = ~r_wr;
    end else if (r_state == HIGH) begin
      SRAM_ADDR  = {r_word, 1'b1};
      SRAM_DQ_O  = r_wr ? r_wdata[31:16] : '0;
      SRAM_DQ_OE = r_wr;
      SRAM_WE_N  = ~r_wr;
    end
  end

  assign rdata = r_rdata;
  assign ready = ((r_state == IDLE) && !w_req) || (r_state == DONE);

endmodule : sram_controller
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Self-checking bench for sram_controller: directed cases plus
//               randomized loads/stores against a word-level reference
//               memory, with an SRAM pin model. Honors SRAM_LAST_READ_HIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;
  import sram_ctrl_pkg::*;

  localparam int W    = 2;
  localparam int BASE = 1024;
  localparam int AW   = 18;
  localparam int WW   = AW - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          MEM_R_EN, MEM_W_EN;
  logic [31:0]   address, wdata, rdata;
  logic          ready;
  logic [AW-1:0] SRAM_ADDR;
  logic [15:0]   SRAM_DQ_O, SRAM_DQ_I;
  logic          SRAM_DQ_OE, SRAM_WE_N;

  always #5 clk = ~clk;

  sram_controller #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (W),
    .SRAM_ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_R_EN   (MEM_R_EN),
    .MEM_W_EN   (MEM_W_EN),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ_O  (SRAM_DQ_O),
    .SRAM_DQ_I  (SRAM_DQ_I),
    .SRAM_DQ_OE (SRAM_DQ_OE),
    .SRAM_WE_N  (SRAM_WE_N)
  );

  // Asynchronous SRAM pin model
  logic [15:0] sram [0:(1<<AW)-1];
  assign SRAM_DQ_I = sram[SRAM_ADDR];
  always @(posedge clk) if (!SRAM_WE_N && SRAM_DQ_OE) sram[SRAM_ADDR] <= SRAM_DQ_O;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: 32-bit words keyed by SRAM word index
  logic [31:0] ref_mem [int];
  logic [31:0] cur_rdata;
`ifdef SRAM_LAST_READ_HIT_EN
  bit buf_vld;
  int buf_word;
`endif

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'(BASE);
    return int'((d >> 2) & 32'((1 << WW) - 1));
  endfunction

  function automatic logic [31:0] get_word(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'h0;
  endfunction

  // Expected outputs for the current cycle
  bit            chk_en = 1'b0;
  logic          exp_ready;
  logic [AW-1:0] exp_addr;
  logic          exp_we_n, exp_oe;
  bit            chk_dq, chk_rd;
  logic [15:0]   exp_dq;
  logic [31:0]   exp_rdata;

  task automatic set_idle_exp(input logic rdy);
    exp_ready = rdy;
    exp_addr  = '0;
    exp_we_n  = 1'b1;
    exp_oe    = 1'b0;
    chk_dq    = 1'b1;
    exp_dq    = 16'h0;
    chk_rd    = 1'b1;
    exp_rdata = cur_rdata;
  endtask

  // Single compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {31'b0, ready}, {31'b0, exp_ready});
      chk("sram_addr", {14'b0, SRAM_ADDR}, {14'b0, exp_addr});
      chk("we_n", {31'b0, SRAM_WE_N}, {31'b0, exp_we_n});
      chk("dq_oe", {31'b0, SRAM_DQ_OE}, {31'b0, exp_oe});
      if (chk_dq) chk("dq_o", {16'b0, SRAM_DQ_O}, {16'b0, exp_dq});
      if (chk_rd) chk("rdata", rdata, exp_rdata);
    end
  end

  task automatic idle_cycle();
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    address  = $urandom;
    wdata    = $urandom;
    set_idle_exp(1'b1);
    @(posedge clk); #1;
  endtask

  // One pipeline access held until completion; inputs scrambled once accepted
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] data, output int lat, output int we_low,
                     output logic [AW-1:0] last_addr);
    int   word;
    int   len;
    bit   hit;
    logic hi;
    logic [WW-1:0] wbits;
    word  = word_of(addr);
    wbits = word[WW-1:0];
    hit   = 1'b0;
`ifdef SRAM_LAST_READ_HIT_EN
    hit = rd && !wr && buf_vld && (buf_word == word);
`endif
    len       = hit ? 1 : 2 * W + 1;
    lat       = -1;
    we_low    = 0;
    last_addr = '0;
    MEM_R_EN  = rd;
    MEM_W_EN  = wr;
    address   = addr;
    wdata     = data;
    for (int k = 0; k <= len; k++) begin
      if (k > 0) begin
        MEM_R_EN = 1'($urandom);
        MEM_W_EN = 1'($urandom);
        address  = $urandom;
        wdata    = $urandom;
      end
      if (k == 0) begin
        set_idle_exp(1'b0);
      end else if (k == len) begin
        if (!wr) cur_rdata = get_word(word);
        set_idle_exp(1'b1);
      end else begin
        hi        = (k > W);
        exp_ready = 1'b0;
        exp_addr  = {wbits, hi};
        exp_we_n  = !wr;
        exp_oe    = wr;
        chk_dq    = wr;
        exp_dq    = hi ? data[31:16] : data[15:0];
        chk_rd    = wr;
        exp_rdata = cur_rdata;
      end
      @(negedge clk);
      if (ready && lat < 0) lat = k;
      if (!SRAM_WE_N) we_low++;
      if (k > 0 && k < len) last_addr = SRAM_ADDR;
      @(posedge clk); #1;
    end
    if (wr) begin
      ref_mem[word] = data;
`ifdef SRAM_LAST_READ_HIT_EN
      buf_vld = 1'b0;
`endif
    end else begin
`ifdef SRAM_LAST_READ_HIT_EN
      buf_vld  = 1'b1;
      buf_word = word;
`endif
    end
  endtask

  // Reset asserted in cycle 2 of a write; low half has already been stored
  task automatic reset_mid_write(input logic [31:0] addr, input logic [31:0] data);
    int            word;
    logic [WW-1:0] wbits;
    logic [31:0]   tmp;
    word     = word_of(addr);
    wbits    = word[WW-1:0];
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b1;
    address  = addr;
    wdata    = data;
    set_idle_exp(1'b0);
    @(posedge clk); #1;
    for (int k = 1; k <= 2; k++) begin
      if (k == 2) begin
        rst = 1'b1;
        MEM_W_EN = 1'b0;
      end
      exp_ready = 1'b0;
      exp_addr  = {wbits, 1'b0};
      exp_we_n  = 1'b0;
      exp_oe    = 1'b1;
      chk_dq    = 1'b1;
      exp_dq    = data[15:0];
      chk_rd    = 1'b1;
      exp_rdata = cur_rdata;
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    cur_rdata = 32'h0;
    tmp       = get_word(word);
    tmp[15:0] = data[15:0];
    ref_mem[word] = tmp;
`ifdef SRAM_LAST_READ_HIT_EN
    buf_vld = 1'b0;
`endif
    set_idle_exp(1'b1);
    @(negedge clk);
    chk("rst_rdata_zero", rdata, 32'h0);
    chk("rst_we_n", {31'b0, SRAM_WE_N}, 32'h1);
    @(posedge clk); #1;
  endtask

  int            lat, wl;
  logic [AW-1:0] la;

  initial begin
    for (int i = 0; i < (1 << AW); i++) sram[i] = 16'h0;
    cur_rdata = 32'h0;
`ifdef SRAM_LAST_READ_HIT_EN
    buf_vld  = 1'b0;
    buf_word = 0;
`endif
    rst = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    address  = 32'h0;
    wdata    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    set_idle_exp(1'b1);
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) idle_cycle();

    // Directed cases with literal expectations
    txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat, wl, la);
    chk("wr_latency", lat, 32'd5);
    chk("wr_we_low_cycles", wl, 32'd4);
    chk("sram_loc0", {16'b0, sram[0]}, 32'h0000BEEF);
    chk("sram_loc1", {16'b0, sram[1]}, 32'h0000DEAD);

    txn(1'b1, 1'b0, 32'd1024, 32'h0, lat, wl, la);
    chk("rd_latency", lat, 32'd5);
    chk("rd_data_1024", rdata, 32'hDEADBEEF);

    txn(1'b1, 1'b1, 32'd1032, 32'h12345678, lat, wl, la);
    chk("both_sram_loc4", {16'b0, sram[4]}, 32'h00005678);
    chk("both_sram_loc5", {16'b0, sram[5]}, 32'h00001234);
    chk("both_rdata_kept", rdata, 32'hDEADBEEF);

    txn(1'b1, 1'b0, 32'd1028, 32'h0, lat, wl, la);
    chk("rd1028_high_addr", {14'b0, la}, 32'd3);
    idle_cycle();

`ifdef SRAM_LAST_READ_HIT_EN
    txn(1'b1, 1'b0, 32'd1024, 32'h0, lat, wl, la);
    chk("hit_first_latency", lat, 32'd5);
    txn(1'b1, 1'b0, 32'd1024, 32'h0, lat, wl, la);
    chk("hit_second_latency", lat, 32'd1);
    chk("hit_rdata", rdata, 32'hDEADBEEF);
    txn(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, lat, wl, la);
    txn(1'b1, 1'b0, 32'd1024, 32'h0, lat, wl, la);
    chk("hit_inval_latency", lat, 32'd5);
    chk("hit_inval_rdata", rdata, 32'hCAFEF00D);
`endif

    reset_mid_write(32'd1024 + 32'd80, 32'hA5A55A5A);
    txn(1'b1, 1'b0, 32'd1024, 32'h0, lat, wl, la);
    chk("post_rst_rd_latency", lat, 32'd5);

    // Randomized traffic over a small window that also wraps below BASE
    for (int n = 0; n < 300; n++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 3));
      a  = 32'(BASE - 16 + 4 * int'($urandom_range(0, 11)) + int'($urandom_range(0, 3)));
      case (op)
        0:       idle_cycle();
        1:       txn(1'b1, 1'b0, a, $urandom, lat, wl, la);
        2:       txn(1'b0, 1'b1, a, $urandom, lat, wl, la);
        default: txn(1'b1, 1'b1, a, $urandom, lat, wl, la);
      endcase
    end
    idle_cycle();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sram_controller
`default_nettype wire
